// File: rtl/shift_rotate_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit.
// SHIFT_ROTATE_CARRY_EN enables the RCL/RCR carry-rotate ops; otherwise they decode as reserved.
package shift_rotate_pkg;

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_ASR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_RCL  = 3'b101;
  localparam logic [2:0] OP_RCR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  // Reserved ops pass data through in one cycle with carry cleared.
  function automatic logic op_is_rsvd(input logic [2:0] op);
`ifdef SHIFT_ROTATE_CARRY_EN
    return (op == OP_RSVD);
`else
    return (op == OP_RSVD) || (op == OP_RCL) || (op == OP_RCR);
`endif
  endfunction

endpackage

// File: rtl/shift_rotate_step.sv
// Combinational single-position shift/rotate step: (op, d, c) -> (d_nxt, c_nxt).
// Carry-rotate cases exist only with SHIFT_ROTATE_CARRY_EN.
module shift_rotate_step #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             c,
  output logic [WIDTH-1:0] d_nxt,
  output logic             c_nxt
);
  import shift_rotate_pkg::*;

  always_comb begin
    d_nxt = d;
    c_nxt = c;
    case (op)
      OP_SHL: begin d_nxt = {d[WIDTH-2:0], 1'b0};     c_nxt = d[WIDTH-1]; end
      OP_SHR: begin d_nxt = {1'b0, d[WIDTH-1:1]};     c_nxt = d[0];       end
      OP_ASR: begin d_nxt = {d[WIDTH-1], d[WIDTH-1:1]}; c_nxt = d[0];     end
      OP_ROL: begin d_nxt = {d[WIDTH-2:0], d[WIDTH-1]}; c_nxt = d[WIDTH-1]; end
      OP_ROR: begin d_nxt = {d[0], d[WIDTH-1:1]};     c_nxt = d[0];       end
`ifdef SHIFT_ROTATE_CARRY_EN
      OP_RCL: {c_nxt, d_nxt} = {d, c};
      OP_RCR: {d_nxt, c_nxt} = {c, d};
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle WIDTH-bit shifter/rotator, one bit position per clock, valid/ready on both sides.
// SHIFT_ROTATE_CARRY_EN enables RCL/RCR; without it they pass through like the reserved op.
module shift_rotate_unit #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             zero
);
  import shift_rotate_pkg::*;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d, step_d;
  logic             wc_q, wc_d, step_c;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             rsvd;

  shift_rotate_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .d     (work_q),
    .c     (wc_q),
    .d_nxt (step_d),
    .c_nxt (step_c)
  );

  assign rsvd = op_is_rsvd(op);

  // Result registers are written only on entry to DONE, so outputs never move mid-shift.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    work_d      = work_q;
    wc_d        = wc_q;
    data_out_d  = data_out_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          work_d = data_in;
          wc_d   = carry_in;
          cnt_d  = amount;
          if (rsvd || (amount == '0)) begin
            state_d     = ST_DONE;
            cnt_d       = '0;
            data_out_d  = data_in;
            carry_out_d = rsvd ? 1'b0 : carry_in;
            zero_d      = (data_in == '0);
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step_d;
        wc_d   = step_c;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d     = ST_DONE;
          data_out_d  = step_d;
          carry_out_d = step_c;
          zero_d      = (step_d == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_SHL;
      work_q      <= '0;
      wc_q        <= 1'b0;
      data_out_q  <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      work_q      <= work_d;
      wc_q        <= wc_d;
      data_out_q  <= data_out_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;

endmodule
